// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and frame pacing.
// BYTE_CYCLES lives here so uart_tx, uart_rx and the arbiter derive it identically.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic int unsigned byte_cycles(
        input int unsigned bps_cnt,
        input int unsigned frame_bits,
        input int unsigned gap_cycles
    );
        return bps_cnt * frame_bits + gap_cycles;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module uart_tx_arb_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
)
(
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    int unsigned w_dist;
    int unsigned w_best;

    // Distance 0 is the slot right after i_last; the smallest distance wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_dist = 0;
        w_best = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - 32'(i_last)) % NUM_REQ;
            if (i_req[j] && (!o_any || w_dist < w_best)) begin
                o_any  = 1'b1;
                w_best = w_dist;
                o_idx  = IW'(j);
            end
        end
        o_gnt[o_idx] = o_any;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers,
// pacing each byte by a full frame time since the serializer has no busy flag.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BPS_CNT    = 5208,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GAP_CYCLES = 2
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic [7:0]                 tx_din,
    output logic                       tx_din_vld,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned BYTE_CYCLES = byte_cycles(BPS_CNT, FRAME_BITS, GAP_CYCLES);
    localparam int unsigned TW          = $clog2(BYTE_CYCLES + 1);
    localparam int unsigned IW          = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_RST   = IW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(BYTE_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_timer;
    logic [7:0]        r_din;
    logic              r_busy;
    logic [IW-1:0]     r_last;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_grant;
    logic              w_tx_vld;
    logic [NUM_REQ-1:0] w_req_rdy;

    uart_tx_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req  (req_vld),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = '0;
        w_grant     = 1'b0;
        w_tx_vld    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_req_rdy   = w_pick_gnt;
                    w_grant     = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_tx_vld    = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_din  <= req_data[{w_pick_idx, 3'b000} +: 8];
                r_last <= w_pick_idx;
                r_busy <= 1'b1;
            end
            // Timer counts LOAD-loaded value down to zero; busy drops with the return to IDLE.
            if (r_state == LOAD) begin
                r_timer <= TIMER_LOAD;
            end else if (r_state == WAIT) begin
                if (r_timer == '0) begin
                    r_busy <= 1'b0;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
            end
        end
    end

    assign req_rdy    = w_req_rdy;
    assign tx_din     = r_din;
    assign tx_din_vld = w_tx_vld;
    assign busy       = r_busy;
    assign grant_id   = r_last;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: slot-scheduling reference model plus directed
// and randomized requester traffic.
module tb_uart_tx_arb;

    localparam int NR   = 4;
    localparam int BPS  = 54;
    localparam int FB   = 10;
    localparam int GAP  = 2;
    localparam int BYTE = BPS * FB + GAP;   // 542

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_vld = '0;
    logic [NR*8-1:0] req_data = '0;
    logic [NR-1:0]   req_rdy;
    logic [7:0]      tx_din;
    logic            tx_din_vld;
    logic            busy;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ    (NR),
        .BPS_CNT    (BPS),
        .FRAME_BITS (FB),
        .GAP_CYCLES (GAP)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_data   (req_data),
        .req_rdy    (req_rdy),
        .tx_din     (tx_din),
        .tx_din_vld (tx_din_vld),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Requesters: each holds its queue head on req_data while the queue is non-empty.
    logic [7:0] src_q [NR][$];
    logic       rst_req = 1'b1;
    logic       chk_en  = 1'b0;

    // Reference model: a grant opens a slot of BYTE+2 cycles; pulse one cycle after grant.
    int         cyc        = 0;
    int         free_at    = 0;
    int         busy_from  = 0;
    int         busy_until = -1;
    int         pulse_at   = -1;
    logic [7:0] m_din      = 8'h00;
    int         m_gid      = NR - 1;

    int         obs_gid [$];
    int         obs_gcyc[$];
    int         obs_pcyc[$];
    logic [7:0] obs_din [$];
    int         busy_cnt = 0;
    logic       prev_vld = 1'b0;

    function automatic int pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic cycle();
        int         e_idx;
        logic [NR-1:0] e_rdy;
        @(negedge clk);
        rst_n = !rst_req;
        for (int i = 0; i < NR; i++) begin
            req_vld[i]          = !rst_req && (src_q[i].size() > 0);
            req_data[i*8 +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
        #1;
        e_idx = (cyc >= free_at) ? pick(req_vld, m_gid) : -1;
        e_rdy = '0;
        if (e_idx >= 0) e_rdy[e_idx] = 1'b1;
        if (chk_en) begin
            check("req_rdy",          int'(req_rdy),    int'(e_rdy));
            check("tx_din_vld",       int'(tx_din_vld), int'(cyc == pulse_at));
            check("tx_din",           int'(tx_din),     int'(m_din));
            check("busy",             int'(busy),       int'(cyc >= busy_from && cyc <= busy_until));
            check("grant_id",         int'(grant_id),   m_gid);
            check("rdy_onehot0",      int'($onehot0(req_rdy)), 1);
            check("vld_adjacent",     int'(tx_din_vld && prev_vld), 0);
            check("grant_while_busy", int'((req_rdy != '0) && busy), 0);
        end
        if (rst_req) begin
            m_din      = 8'h00;
            m_gid      = NR - 1;
            free_at    = cyc + 1;
            busy_from  = 0;
            busy_until = -1;
            pulse_at   = -1;
        end else if (e_idx >= 0) begin
            m_gid      = e_idx;
            m_din      = src_q[e_idx][0];
            pulse_at   = cyc + 1;
            busy_from  = cyc + 1;
            busy_until = cyc + BYTE + 1;
            free_at    = cyc + BYTE + 2;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_rdy[i] && req_vld[i]) begin
                obs_gid.push_back(i);
                obs_gcyc.push_back(cyc);
                void'(src_q[i].pop_front());
            end
        end
        if (tx_din_vld) begin
            obs_pcyc.push_back(cyc);
            obs_din.push_back(tx_din);
        end
        if (busy) busy_cnt++;
        prev_vld = tx_din_vld;
        cyc++;
    endtask

    task automatic clear_obs();
        obs_gid.delete();
        obs_gcyc.delete();
        obs_pcyc.delete();
        obs_din.delete();
        busy_cnt = 0;
    endtask

    task automatic reset_dut();
        for (int i = 0; i < NR; i++) src_q[i].delete();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        clear_obs();
    endtask

    initial begin
        int t0;

        // Model self-test against hand-derived picks.
        check("pick_after_reset", pick(4'b1111, 3), 0);
        check("pick_wrap",        pick(4'b1010, 1), 3);
        check("pick_self_last",   pick(4'b0001, 0), 0);
        check("pick_none",        pick(4'b0000, 2), -1);

        // Power-on reset, then literal reset values.
        rst_req = 1'b1;
        cycle();
        cycle();
        rst_req = 1'b0;
        chk_en  = 1'b1;
        cycle();
        check("rst_busy",     int'(busy),       0);
        check("rst_grant_id", int'(grant_id),   3);
        check("rst_tx_din",   int'(tx_din),     0);
        check("rst_tx_vld",   int'(tx_din_vld), 0);
        check("rst_req_rdy",  int'(req_rdy),    0);
        clear_obs();

        // Single request from requester 2.
        src_q[2].push_back(8'hA5);
        t0 = cyc;
        repeat (600) cycle();
        check("single_grants", obs_gid.size(), 1);
        if (obs_gid.size() >= 1 && obs_pcyc.size() >= 1) begin
            check("single_gid",     obs_gid[0], 2);
            check("single_gcyc",    obs_gcyc[0] - t0, 0);
            check("single_latency", obs_pcyc[0] - obs_gcyc[0], 1);
            check("single_din",     int'(obs_din[0]), 8'hA5);
        end
        check("single_busy_len", busy_cnt, 543);
        check("single_grant_id", int'(grant_id), 2);

        // All four requesting continuously.
        reset_dut();
        for (int i = 0; i < NR; i++) begin
            src_q[i].push_back(8'h10 + 8'(i));
            src_q[i].push_back(8'h10 + 8'(i));
        end
        repeat (8 * 544 + 20) cycle();
        check("all_grants", obs_gid.size(), 8);
        if (obs_gid.size() >= 5 && obs_pcyc.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("all_order", obs_gid[k], k % 4);
                check("all_din",   int'(obs_din[k]), 8'h10 + (k % 4));
                if (k > 0) check("all_spacing", obs_pcyc[k] - obs_pcyc[k-1], 544);
            end
        end

        // Fairness: requester 1 always pending, requester 3 raised once mid-WAIT.
        reset_dut();
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'h21 + 8'(k));
        repeat (100) cycle();
        src_q[3].push_back(8'h33);
        repeat (5 * 544 + 20) cycle();
        check("fair_grants", obs_gid.size(), 5);
        if (obs_gid.size() >= 4) begin
            check("fair_0", obs_gid[0], 1);
            check("fair_1", obs_gid[1], 3);
            check("fair_2", obs_gid[2], 1);
            check("fair_3", obs_gid[3], 1);
        end

        // Withdrawn request: requester 0 drops before the arbiter returns to IDLE.
        reset_dut();
        src_q[2].push_back(8'h77);
        repeat (100) cycle();
        src_q[0].push_back(8'h99);
        repeat (300) cycle();
        src_q[0].delete();
        repeat (400) cycle();
        check("wd_grants",   obs_gid.size(),  1);
        check("wd_pulses",   obs_pcyc.size(), 1);
        check("wd_busy_len", busy_cnt, 543);
        check("wd_busy_end", int'(busy), 0);

        // Reset in the middle of WAIT.
        reset_dut();
        src_q[2].push_back(8'h55);
        repeat (201) cycle();
        check("midrst_busy_before", int'(busy), 1);
        reset_dut();
        for (int i = 0; i < NR; i++) src_q[i].push_back(8'h60 + 8'(i));
        cycle();
        check("midrst_busy",     int'(busy),     0);
        check("midrst_grant_id", int'(grant_id), 3);
        check("midrst_rdy",      int'(req_rdy),  1);
        repeat (4 * 544 + 20) cycle();
        if (obs_gid.size() >= 1) check("midrst_first", obs_gid[0], 0);
        check("midrst_grants", obs_gid.size(), 4);

        // Randomized traffic with withdrawals and occasional resets.
        reset_dut();
        repeat (15000) begin
            if ($urandom_range(0, 99) < 3) begin
                int r;
                r = int'($urandom_range(0, NR - 1));
                if (src_q[r].size() < 3) src_q[r].push_back(8'($urandom));
            end
            if ($urandom_range(0, 999) == 0) src_q[$urandom_range(0, NR - 1)].delete();
            rst_req = ($urandom_range(0, 4999) == 0);
            cycle();
            rst_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
